// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for a single register-file write port, plus a
// pending-write scoreboard that stalls issue on RAW/WAW hazards.
// Port 0 is the single-cycle ALU path. Port 1 is the multi-cycle load/mul path.
// Port 1 gets one forced win after STARVE_MAX consecutive losses.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [4:0]        req0_dst,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [4:0]        req1_dst,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              issue_valid,
  input  logic [4:0]        issue_src_a,
  input  logic [4:0]        issue_src_b,
  input  logic [4:0]        issue_dst,
  output logic              issue_stall,
  output logic [DATA_W-1:0] wb,
  output logic [4:0]        dst,
  output logic              reg_write,
  output logic [31:0]       pending
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0]     starve_q, starve_d;
  logic [DATA_W-1:0] wb_q, wb_d;
  logic [4:0]        dst_q, dst_d;
  logic              reg_write_q, reg_write_d;
  logic [31:0]       pending_q, pending_d;
  logic              grant0, grant1;
  logic              hit_a, hit_b, hit_d;
  logic              issue_fire;

  // Grant selection: a lone requester wins; on a tie, port 0 wins unless port 1 is starved.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst_n) begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end else if (req0_valid && req1_valid) begin
      if (starve_q == STARVE_LIM) begin
        grant1 = 1'b1;
      end else begin
        grant0 = 1'b1;
      end
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Hazard detection against registered pending bits; register 0 never hazards.
  always_comb begin
    hit_a       = (issue_src_a != 5'd0) && pending_q[issue_src_a];
    hit_b       = (issue_src_b != 5'd0) && pending_q[issue_src_b];
    hit_d       = (issue_dst   != 5'd0) && pending_q[issue_dst];
    issue_stall = issue_valid && (hit_a || hit_b || hit_d);
    issue_fire  = issue_valid && !(hit_a || hit_b || hit_d);
  end

  // Next state for the starvation counter, write register and scoreboard.
  always_comb begin
    starve_d    = starve_q;
    wb_d        = wb_q;
    dst_d       = dst_q;
    reg_write_d = 1'b0;
    pending_d   = pending_q;

    if (grant1) begin
      starve_d = {SW{1'b0}};
    end else if (req1_valid && grant0 && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + {{(SW-1){1'b0}}, 1'b1};
    end else begin
      starve_d = starve_q;
    end

    if (grant0) begin
      wb_d        = req0_data;
      dst_d       = req0_dst;
      reg_write_d = (req0_dst != 5'd0);
    end else if (grant1) begin
      wb_d        = req1_data;
      dst_d       = req1_dst;
      reg_write_d = (req1_dst != 5'd0);
    end else begin
      reg_write_d = 1'b0;
    end

    // The clear lands with the register-file commit; a same-edge set overrides it.
    if (reg_write_q) begin
      pending_d[dst_q] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (issue_fire && (issue_dst != 5'd0)) begin
      pending_d[issue_dst] = 1'b1;
    end else begin
      pending_d = pending_d;
    end
    pending_d[0] = 1'b0;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      starve_q    <= {SW{1'b0}};
      wb_q        <= {DATA_W{1'b0}};
      dst_q       <= 5'd0;
      reg_write_q <= 1'b0;
      pending_q   <= 32'd0;
    end else begin
      starve_q    <= starve_d;
      wb_q        <= wb_d;
      dst_q       <= dst_d;
      reg_write_q <= reg_write_d;
      pending_q   <= pending_d;
    end
  end

  assign wb        = wb_q;
  assign dst       = dst_q;
  assign reg_write = reg_write_q;
  assign pending   = pending_q;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between two writeback sources: port 0 is the single-cycle ALU path and port 1 is the multi-cycle load/mul path. The block also keeps a pending-write scoreboard over the 32 architectural registers. It stalls instruction issue on RAW and WAW hazards against in-flight writes. It sits between the execute/memory units and the register file, and drives the register file's wb, dst and reg_write inputs directly.

Parameters:
DATA_W, 32, writeback data width
STARVE_MAX, 3, consecutive port-1 losses after which port 1 gets priority for one grant

Ports:
CLOCK_50  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous reset, active low
req0_valid  in  1  ALU writeback request
req0_dst  in  5  ALU destination register
req0_data  in  DATA_W  ALU result
req0_ready  out  1  ALU request accepted this cycle
req1_valid  in  1  load/mul writeback request
req1_dst  in  5  load/mul destination register
req1_data  in  DATA_W  load/mul result
req1_ready  out  1  load/mul request accepted this cycle
issue_valid  in  1  decode wants to issue an instruction
issue_src_a  in  5  source register A
issue_src_b  in  5  source register B
issue_dst  in  5  destination register (0 = no write)
issue_stall  out  1  hazard, hold issue
wb  out  DATA_W  to register file write data
dst  out  5  to register file write address
reg_write  out  1  to register file write enable
pending  out  32  scoreboard bits, for debug

Behaviour:
- Reset, sampled on the CLOCK_50 edge with rst_n=0:
  - wb=0, dst=0, reg_write=0, pending=0, starve counter=0.
  - req0_ready and req1_ready are 0 while rst_n=0.
  - Reset overrides any request or issue in that cycle.
- Arbitration is combinational within a cycle:
  - Only one valid: that port is granted.
  - Both valid: port 0 wins, unless starve counter == STARVE_MAX, in which case port 1 wins.
  - reqN_ready = grant to port N. A fire is valid && ready.
  - A requester holds valid, dst and data stable until ready.
- Starve counter:
  - Increments, saturating at STARVE_MAX, when req1_valid=1 and port 0 is granted.
  - Clears when port 1 fires.
  - Holds when req1_valid=0.
- Write output is registered, with 1-cycle latency:
  - On the edge after a fire: wb=data, dst=dst, reg_write = (dst != 0).
  - With no fire: reg_write=0, and wb/dst hold their previous values.
  - The register file commits on the following edge.
- Scoreboard:
  - issue_fire = issue_valid && !issue_stall.
  - On the issue_fire edge with issue_dst != 0: pending[issue_dst] is set.
  - On any edge where the registered reg_write=1: pending[dst] is cleared. This coincides with the register file commit.
  - Set and clear to the same register on the same edge: set wins.
  - pending[0] is always 0.
- Stall is combinational from the registered pending bits:
  - issue_stall = issue_valid && (pending[issue_src_a] || pending[issue_src_b] || pending[issue_dst]).
  - Any term indexing register 0 is false.
  - No bypass: a clear does not unstall until the cycle after the clear edge.
- A writeback to a register with pending=0 is legal. It is written and leaves pending=0.
- Two requests to the same dst in one cycle: the losing port stays waiting and writes later. Ordering is the issuer's responsibility; the scoreboard's WAW stall prevents this case.
- Reset mid-operation:
  - Any in-flight registered write is dropped (reg_write=0).
  - All pending bits are cleared.
  - Requesters must re-present their requests after reset.

Test Plan:
1. Reset with all inputs active -> reg_write=0, pending=0, both readies 0. Release rst_n with req0_valid=1, dst=5, data=0xAA -> req0_ready=1 that cycle; next cycle reg_write=1, dst=5, wb=0xAA.
2. Issue dst=7 (fires), then issue src_a=7 -> issue_stall=1. Port 1 writes dst 7 with 0x1234 -> pending[7] clears on the reg_write edge; stall drops the cycle after.
3. Both ports valid every cycle, STARVE_MAX=3 -> grant sequence 0,0,0,1,0,0,0,1. Counter returns to 0 after each port-1 fire.
4. Request with dst=0 -> ready=1, reg_write stays 0. Issue dst=0 -> pending unchanged, no stall on src 0.
5. issue_fire on dst=9 on the same edge that reg_write clears 9 -> pending[9]=1 afterwards. A further issue with src_b=9 stalls.
6. Assert rst_n=0 while pending[3]=1 and a write to reg 3 is registered -> next cycle reg_write=0, pending=0, issue of src 3 does not stall.
